keypad_scanner: RTL and testbench

Upstream stage for the calculator top. It scans the 4x4 matrix keypad by driving one column low at a time on key_out and sampling the rows on key_in. It debounces the result and emits a single-cycle key_valid strobe with a 4-bit key_code per debounced press. This replaces the ad-hoc column/row polling inside the calculator top; the top consumes only key_valid/key_code/key_held.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_debounce.sv | 117 +++++++++++
 rtl/keypad_scanner.sv | 112 +++++++++++
 tb/tb_keypad_scanner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner and its debounce FSM.
// Holds key-code field widths, the debounce state and scan-result
// encodings, and the column drive table.
package keypad_pkg;

  localparam int ROW_W  = 2;
  localparam int COL_W  = 2;
  localparam int CODE_W = ROW_W + COL_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_REL_DB   = 2'd3
  } db_state_e;

  typedef enum logic [1:0] {
    RES_EMPTY  = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } scan_res_e;

  // One-hot-low column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [COL_W-1:0] idx);
    logic [3:0] drv;
    case (idx)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      default: drv = 4'b0111;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM: accepts a key after DEBOUNCE_SCANS identical single-key scans,
// releases after DEBOUNCE_SCANS empty scans. Latency: o_key_valid one cycle
// after the accepting scan-end strobe. No backpressure: o_key_valid is a strobe.
// Ports: clk, rst (sync, active-high); i_scan_end strobe with i_scan_res and
// i_scan_code for the finished scan; o_key_valid, o_key_code, o_key_held.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_scan_end,
  input  scan_res_e         i_scan_res,
  input  logic [CODE_W-1:0] i_scan_code,
  output logic              o_key_valid,
  output logic [CODE_W-1:0] o_key_code,
  output logic              o_key_held
);

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  db_state_e         r_state;
  logic [3:0]        r_cnt;
  logic [CODE_W-1:0] r_cand;
  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic              r_held;

  logic w_cnt_done;
  logic w_same_single;

  // Counter reaches the threshold on this scan.
  assign w_cnt_done    = (r_cnt + 4'd1) == DB_N;
  assign w_same_single = (i_scan_res == RES_SINGLE) && (i_scan_code == r_cand);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_cand  <= '0;
      r_valid <= 1'b0;
      r_code  <= '0;
      r_held  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_scan_end) begin
        case (r_state)
          ST_IDLE: begin
            if (i_scan_res == RES_SINGLE) begin
              r_cand <= i_scan_code;
              if (DB_N == 4'd1) begin
                r_state <= ST_PRESSED;
                r_cnt   <= 4'd0;
                r_code  <= i_scan_code;
                r_held  <= 1'b1;
                r_valid <= 1'b1;
              end else begin
                r_state <= ST_PRESS_DB;
                r_cnt   <= 4'd1;
              end
            end
          end
          ST_PRESS_DB: begin
            if (w_same_single) begin
              if (w_cnt_done) begin
                r_state <= ST_PRESSED;
                r_cnt   <= 4'd0;
                r_code  <= r_cand;
                r_held  <= 1'b1;
                r_valid <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= 4'd0;
            end
          end
          ST_PRESSED: begin
            // Key changes and ghosting are ignored until a clean release.
            if (i_scan_res == RES_EMPTY) begin
              if (DB_N == 4'd1) begin
                r_state <= ST_IDLE;
                r_cnt   <= 4'd0;
                r_held  <= 1'b0;
              end else begin
                r_state <= ST_REL_DB;
                r_cnt   <= 4'd1;
              end
            end
          end
          default: begin
            if (i_scan_res == RES_EMPTY) begin
              if (w_cnt_done) begin
                r_state <= ST_IDLE;
                r_cnt   <= 4'd0;
                r_held  <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end else begin
              // Release bounce: back to held without a new pulse.
              r_state <= ST_PRESSED;
              r_cnt   <= 4'd0;
            end
          end
        endcase
      end
    end
  end

  assign o_key_valid = r_valid;
  assign o_key_code  = r_code;
  assign o_key_held  = r_held;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, per-scan accumulation.
// Latency: accept at end of the DEBOUNCE_SCANS-th full scan plus <=1 scan + 2 sync.
// No backpressure: key_valid is a one-cycle strobe, consumer must take it.
// Ports: clk, rst (sync, active-high); key_in rows (active-low, async);
// key_out column drive (one-hot-low); key_valid, key_code {row,col}, key_held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_in,
  output logic [3:0]        key_out,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held
);

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

  logic [3:0]        r_sync1;
  logic [3:0]        r_sync2;
  logic [19:0]       r_div;
  logic [COL_W-1:0]  r_col;
  logic [1:0]        r_acc_cnt;
  logic [CODE_W-1:0] r_acc_code;

  logic              w_tick;
  logic [3:0]        w_hits;
  logic [2:0]        w_pop;
  logic [1:0]        w_col_cnt;
  logic [ROW_W-1:0]  w_row_idx;
  logic [1:0]        w_base_cnt;
  logic [CODE_W-1:0] w_base_code;
  logic [2:0]        w_sum;
  logic [1:0]        w_new_cnt;
  logic [CODE_W-1:0] w_new_code;
  scan_res_e         w_res;
  logic              w_scan_end;

  assign w_tick = (r_div == DIV_LAST);
  assign w_hits = ~r_sync2;
  assign w_pop  = {2'b0, w_hits[0]} + {2'b0, w_hits[1]}
                + {2'b0, w_hits[2]} + {2'b0, w_hits[3]};
  assign w_col_cnt = (w_pop >= 3'd2) ? 2'd2 : w_pop[1:0];

  // Lowest pressed row wins within a column.
  always_comb begin
    w_row_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (w_hits[i]) w_row_idx = ROW_W'(i);
    end
  end

  // Column 0 starts a fresh scan, so ignore leftovers from the previous one.
  assign w_base_cnt  = (r_col == '0) ? 2'd0 : r_acc_cnt;
  assign w_base_code = (r_col == '0) ? '0 : r_acc_code;
  assign w_sum       = {1'b0, w_base_cnt} + {1'b0, w_col_cnt};
  assign w_new_cnt   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_new_code  = (w_base_cnt == 2'd0 && w_col_cnt != 2'd0)
                     ? {w_row_idx, r_col} : w_base_code;

  always_comb begin
    case (w_new_cnt)
      2'd0:    w_res = RES_EMPTY;
      2'd1:    w_res = RES_SINGLE;
      default: w_res = RES_MULTI;
    endcase
  end

  assign w_scan_end = w_tick && (r_col == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 4'hF;
      r_sync2    <= 4'hF;
      r_div      <= 20'd0;
      r_col      <= '0;
      r_acc_cnt  <= 2'd0;
      r_acc_code <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      if (w_tick) begin
        r_div      <= 20'd0;
        r_col      <= r_col + 2'd1;
        r_acc_cnt  <= w_new_cnt;
        r_acc_code <= w_new_code;
      end else begin
        r_div <= r_div + 20'd1;
      end
    end
  end

  assign key_out = col_drive(r_col);

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .i_scan_end  (w_scan_end),
    .i_scan_res  (w_res),
    .i_scan_code (w_new_code),
    .o_key_valid (key_valid),
    .o_key_code  (key_code),
    .o_key_held  (key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_SCANS=3.
// The matrix is modelled by pulling row r low while the pressed key's
// column is driven low; stimulus changes only on scan boundaries.
module tb_keypad_scanner;

  localparam int DIV = 8;
  localparam int DB  = 3;
  localparam int SCAN_CYC = DIV * 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_in;
  logic [3:0] key_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [15:0] keys = 16'h0;   // bit k = row*4 + col pressed

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (DIV),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always_comb begin
    key_in = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (keys[k] && !key_out[k[1:0]]) key_in[k[3:2]] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scan-level reference: counts keys in a scan and applies the
  // press/release streak rules directly.
  logic       m_held;
  int         m_streak;
  int         m_rel;
  logic [3:0] m_cand;
  logic [3:0] m_code;

  task automatic model_reset();
    m_held = 1'b0; m_streak = 0; m_rel = 0; m_cand = 4'h0; m_code = 4'h0;
  endtask

  task automatic model_scan(input logic [15:0] k, output int exp_pulse);
    int n = 0;
    logic [3:0] first = 4'h0;
    bit found = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[r*4+c]) begin
          n++;
          if (!found) begin first = 4'(r*4+c); found = 1; end
        end
    exp_pulse = 0;
    if (!m_held) begin
      if (n == 1 && (m_streak == 0 || first == m_cand)) begin
        if (m_streak == 0) m_cand = first;
        m_streak++;
        if (m_streak == DB) begin
          m_held = 1'b1; m_code = m_cand; m_streak = 0; exp_pulse = 1;
        end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (n == 0) begin
        m_rel++;
        if (m_rel == DB) begin m_held = 1'b0; m_rel = 0; end
      end else begin
        m_rel = 0;
      end
    end
  endtask

  // One full scan: presents k, counts key_valid cycles, advances the model.
  task automatic run_scan(input logic [15:0] k, output int pulses, output int exp_pulse);
    keys = k;
    pulses = 0;
    repeat (SCAN_CYC) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid) pulses++;
    end
    model_scan(k, exp_pulse);
  endtask

  task automatic scan_and_check(input logic [15:0] k, input string tag);
    int p, ep;
    run_scan(k, p, ep);
    check({tag, " pulses"}, 16'(p), 16'(ep));
    check({tag, " code"}, {12'h0, key_code}, {12'h0, m_code});
    check({tag, " held"}, {15'h0, key_held}, {15'h0, m_held});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst key_out", {12'h0, key_out}, 16'h000E);
    check("rst key_valid", {15'h0, key_valid}, 16'h0);
    check("rst key_code", {12'h0, key_code}, 16'h0);
    check("rst key_held", {15'h0, key_held}, 16'h0);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] keys;
    int          n;
    int          pulses;
    logic [3:0]  code;
    logic        held;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int p, ep, tot;
    logic [3:0] rot_exp [5];
    int         rot_cyc [5];

    // Directed scan groups: keys held for n scans, expected pulse total,
    // then key_code/key_held at the end of the group.
    // Clean press row2/col1 (code 9), then release.
    vecs.push_back('{16'h0200, 2, 0, 4'h0, 1'b0});
    vecs.push_back('{16'h0200, 1, 1, 4'h9, 1'b1});
    vecs.push_back('{16'h0200, 3, 0, 4'h9, 1'b1});
    vecs.push_back('{16'h0000, 2, 0, 4'h9, 1'b1});
    vecs.push_back('{16'h0000, 1, 0, 4'h9, 1'b0});
    // Bounce on row1/col1 (code 5), then a clean 3-scan press.
    vecs.push_back('{16'h0020, 2, 0, 4'h9, 1'b0});
    vecs.push_back('{16'h0000, 1, 0, 4'h9, 1'b0});
    vecs.push_back('{16'h0020, 2, 0, 4'h9, 1'b0});
    vecs.push_back('{16'h0000, 1, 0, 4'h9, 1'b0});
    vecs.push_back('{16'h0020, 2, 0, 4'h9, 1'b0});
    vecs.push_back('{16'h0020, 1, 1, 4'h5, 1'b1});
    vecs.push_back('{16'h0000, 3, 0, 4'h5, 1'b0});
    // Two keys together: row0/col0 and row3/col2.
    vecs.push_back('{16'h4001, 10, 0, 4'h5, 1'b0});
    vecs.push_back('{16'h0000, 1, 0, 4'h5, 1'b0});
    // Long hold row1/col3 (code 7) with a 1-scan dropout at scan 10.
    vecs.push_back('{16'h0080, 2, 0, 4'h5, 1'b0});
    vecs.push_back('{16'h0080, 1, 1, 4'h7, 1'b1});
    vecs.push_back('{16'h0080, 6, 0, 4'h7, 1'b1});
    vecs.push_back('{16'h0000, 1, 0, 4'h7, 1'b1});
    vecs.push_back('{16'h0080, 10, 0, 4'h7, 1'b1});
    vecs.push_back('{16'h0000, 2, 0, 4'h7, 1'b1});
    vecs.push_back('{16'h0000, 1, 0, 4'h7, 1'b0});

    rot_cyc = '{7, 8, 16, 24, 32};
    rot_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset values and column rotation.
    apply_reset();
    tot = 0;
    for (int i = 0; i < 5; i++) begin
      while (tot < rot_cyc[i]) begin @(posedge clk); tot++; end
      @(negedge clk);
      check($sformatf("rotate c%0d", rot_cyc[i]), {12'h0, key_out}, {12'h0, rot_exp[i]});
    end

    // Directed table.
    apply_reset();
    for (int v = 0; v < vecs.size(); v++) begin
      tot = 0;
      for (int s = 0; s < vecs[v].n; s++) begin
        run_scan(vecs[v].keys, p, ep);
        tot += p;
      end
      check($sformatf("vec%0d pulses", v), 16'(tot), 16'(vecs[v].pulses));
      check($sformatf("vec%0d code", v), {12'h0, key_code}, {12'h0, vecs[v].code});
      check($sformatf("vec%0d held", v), {15'h0, key_held}, {15'h0, vecs[v].held});
    end

    // Randomised groups against the scan-level model.
    for (int g = 0; g < 20; g++) begin
      logic [15:0] k;
      int sel, n;
      sel = $urandom_range(0, 9);
      if (sel < 3)      k = 16'h0;
      else if (sel < 8) k = 16'h1 << $urandom_range(0, 15);
      else              k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      n = $urandom_range(1, 5);
      for (int s = 0; s < n; s++) scan_and_check(k, $sformatf("rand g%0d s%0d", g, s));
    end

    // Reset while in press debounce with the key still down (row2/col3, code B).
    for (int s = 0; s < DB; s++) scan_and_check(16'h0, "pre-rst idle");
    for (int s = 0; s < 2; s++) scan_and_check(16'h0800, "pre-rst press");
    repeat (10) @(posedge clk);
    apply_reset();
    tot = 0;
    for (int s = 0; s < 2; s++) begin
      run_scan(16'h0800, p, ep);
      tot += p;
    end
    check("post-rst early pulses", 16'(tot), 16'h0);
    check("post-rst early held", {15'h0, key_held}, 16'h0);
    run_scan(16'h0800, p, ep);
    check("post-rst pulse", 16'(p), 16'h1);
    check("post-rst code", {12'h0, key_code}, 16'h000B);
    check("post-rst held", {15'h0, key_held}, 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
